// File: rtl/fft_r2_iter_if.sv
// rtl/fft_r2_iter_if.sv - sample-in / bin-out stream bundle for the iterative radix-2 FFT engine.
interface fft_r2_iter_if #(
  parameter int DW = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_re;
  logic signed [DW-1:0] s_im;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_re;
  logic signed [DW-1:0] m_im;
  logic                 m_last;

  modport slave (
    input  s_valid, s_re, s_im, m_ready,
    output s_ready, m_valid, m_re, m_im, m_last
  );

  modport master (
    output s_valid, s_re, s_im, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_last
  );
endinterface

// File: rtl/fft_r2_iter.sv
// rtl/fft_r2_iter.sv - iterative in-place radix-2 DIT FFT, one butterfly per clock.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (result = DFT/N_PTS, ovf never set).
module fft_r2_iter #(
  parameter int N_PTS = 16,
  parameter int DW    = 16,
  parameter int TW    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fft_r2_iter_if.slave bus,
  output logic         busy,
  output logic         ovf
);
  localparam int L  = $clog2(N_PTS);
  localparam int BW = L - 1;
  localparam int SW = 4;
  localparam int PW = DW + TW;
  localparam logic [L-1:0]         CNT_LAST = L'(N_PTS - 1);
  localparam logic [SW-1:0]        STG_LAST = SW'(L - 1);
  localparam logic signed [PW-1:0] RND      = PW'(1) << (TW - 2);
  localparam real    PI     = 3.14159265358979323846;
  localparam real    WSCALE = (1 << (TW - 1)) * 1.0;
  localparam integer WMAX   = (1 << (TW - 1)) - 1;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t          state, state_n;
  logic [L-1:0]    cnt;
  logic [SW-1:0]   stage;
  logic [BW-1:0]   bfly;
  logic            load_hs, out_hs, bfly_en, bfly_ovf;
  logic            s_ready_c, m_valid_c, busy_c;

  logic signed [DW-1:0] mem_re [N_PTS];
  logic signed [DW-1:0] mem_im [N_PTS];
  logic signed [TW-1:0] tw_re  [N_PTS/2];
  logic signed [TW-1:0] tw_im  [N_PTS/2];

  // Twiddles W^t = cos - j*sin, rounded to nearest with +1.0 clipped to the largest code.
  for (genvar i = 0; i < N_PTS/2; i++) begin : g_tw
    localparam real    ANG = 2.0 * PI * i / N_PTS;
    localparam real    CF  = $cos(ANG) * WSCALE;
    localparam real    SF  = -$sin(ANG) * WSCALE;
    localparam integer CR  = (CF >= 0.0) ? $rtoi(CF + 0.5) : -$rtoi(0.5 - CF);
    localparam integer SR  = (SF >= 0.0) ? $rtoi(SF + 0.5) : -$rtoi(0.5 - SF);
    localparam integer CS  = (CR > WMAX) ? WMAX : CR;
    localparam integer SS  = (SR > WMAX) ? WMAX : SR;
    assign tw_re[i] = TW'(CS);
    assign tw_im[i] = TW'(SS);
  end

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  logic [L-1:0]  bl, half, pos, top_a, bot_a;
  logic [BW-1:0] tidx;

  assign bl    = {1'b0, bfly};
  assign half  = L'(1) << stage;
  assign pos   = bl & (half - L'(1));
  assign top_a = ((bl >> stage) << (int'(stage) + 1)) | pos;
  assign bot_a = top_a | half;
  assign tidx  = BW'(pos << (BW - int'(stage)));

  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [PW-1:0] prod_re, prod_im, rnd_re, rnd_im;
  logic signed [DW:0]   p_re, p_im, ax_re, ax_im;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0] nt_re, nt_im, nb_re, nb_im;
  logic                 unused_round, unused_lsb;

  assign a_re = mem_re[top_a];
  assign a_im = mem_im[top_a];
  assign b_re = mem_re[bot_a];
  assign b_im = mem_im[bot_a];
  assign w_re = tw_re[tidx];
  assign w_im = tw_im[tidx];

  assign prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
  assign prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
  assign rnd_re  = prod_re + RND;
  assign rnd_im  = prod_im + RND;
  assign p_re    = rnd_re[PW-1:TW-1];
  assign p_im    = rnd_im[PW-1:TW-1];
  assign unused_round = ^{rnd_re[TW-2:0], rnd_im[TW-2:0]};

  assign ax_re  = {a_re[DW-1], a_re};
  assign ax_im  = {a_im[DW-1], a_im};
  assign sum_re = ax_re + p_re;
  assign sum_im = ax_im + p_im;
  assign dif_re = ax_re - p_re;
  assign dif_im = ax_im - p_im;

`ifdef FFT_STAGE_SCALE_EN
  assign nt_re      = sum_re[DW:1];
  assign nt_im      = sum_im[DW:1];
  assign nb_re      = dif_re[DW:1];
  assign nb_im      = dif_im[DW:1];
  assign bfly_ovf   = 1'b0;
  assign unused_lsb = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
`else
  // Wrap to DW bits; overflow whenever the dropped bit disagrees with the new sign.
  assign nt_re      = sum_re[DW-1:0];
  assign nt_im      = sum_im[DW-1:0];
  assign nb_re      = dif_re[DW-1:0];
  assign nb_im      = dif_im[DW-1:0];
  assign bfly_ovf   = (sum_re[DW] ^ sum_re[DW-1]) | (sum_im[DW] ^ sum_im[DW-1]) |
                      (dif_re[DW] ^ dif_re[DW-1]) | (dif_im[DW] ^ dif_im[DW-1]);
  assign unused_lsb = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    busy_c    = 1'b0;
    load_hs   = 1'b0;
    out_hs    = 1'b0;
    bfly_en   = 1'b0;
    case (state)
      S_LOAD: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          load_hs = 1'b1;
          if (cnt == CNT_LAST) state_n = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy_c  = 1'b1;
        bfly_en = 1'b1;
        if (stage == STG_LAST && (&bfly)) state_n = S_UNLOAD;
      end
      S_UNLOAD: begin
        busy_c    = 1'b1;
        m_valid_c = 1'b1;
        if (bus.m_ready) begin
          out_hs = 1'b1;
          if (cnt == CNT_LAST) state_n = S_LOAD;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // cnt is shared by load and unload; it wraps to zero at the end of each phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      stage <= '0;
      bfly  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (load_hs || out_hs) cnt <= cnt + L'(1);
      if (load_hs && cnt == '0) ovf <= 1'b0;
      if (bfly_en) begin
        bfly <= bfly + BW'(1);
        if (&bfly) stage <= (stage == STG_LAST) ? '0 : stage + SW'(1);
        if (bfly_ovf) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_hs) begin
      mem_re[bitrev(cnt)] <= bus.s_re;
      mem_im[bitrev(cnt)] <= bus.s_im;
    end
    if (bfly_en) begin
      mem_re[top_a] <= nt_re;
      mem_im[top_a] <= nt_im;
      mem_re[bot_a] <= nb_re;
      mem_im[bot_a] <= nb_im;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_re    = m_valid_c ? mem_re[cnt] : '0;
  assign bus.m_im    = m_valid_c ? mem_im[cnt] : '0;
  assign bus.m_last  = m_valid_c && (cnt == CNT_LAST);
  assign busy        = busy_c;
endmodule

// File: tb/tb_fft_r2_iter.sv
// tb/tb_fft_r2_iter.sv - directed bench for fft_r2_iter (N_PTS=16), honours FFT_STAGE_SCALE_EN.
module tb_fft_r2_iter;
  localparam int N = 16;
`ifdef FFT_STAGE_SCALE_EN
  localparam int IMP = 62, DC0 = 1000, PAIR = 125, COS_PEAK = 4096, COS_TOL = 2;
  localparam logic OVF_EXP = 1'b0;
  localparam int COS_TAB[N] = '{8192, 7568, 5793, 3135, 0, -3135, -5793, -7568,
                                -8192, -7568, -5793, -3135, 0, 3135, 5793, 7568};
`else
  localparam int IMP = 1000, DC0 = 16000, PAIR = 2000, COS_PEAK = 8192, COS_TOL = 4;
  localparam logic OVF_EXP = 1'b1;
  localparam int COS_TAB[N] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                                -1024, -946, -724, -392, 0, 392, 724, 946};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, ovf;

  fft_r2_iter_if #(.DW(16)) bus ();

  fft_r2_iter #(.N_PTS(N), .DW(16), .TW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   xr[N], xi[N], yr[N], yi[N];
  logic yl[N];
  logic y_ovf;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int re, input int im, output bit to);
    int cyc = 0;
    bus.s_valid = 1'b1;
    bus.s_re    = 16'(re);
    bus.s_im    = 16'(im);
    while (!bus.s_ready && cyc < 500) begin
      tick();
      cyc++;
    end
    to = (cyc >= 500);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, output bit to);
    bit t;
    to = 1'b0;
    for (int k = 0; k < N; k++) begin
      send_sample(xr[k], xi[k], t);
      to |= t;
      if (k < N - 1) repeat (gap) tick();
    end
  endtask

  task automatic recv_frame(output int got);
    int cyc = 0;
    got = 0;
    bus.m_ready = 1'b1;
    while (got < N && cyc < 2000) begin
      if (bus.m_valid) begin
        if (got == 0) y_ovf = ovf;
        yr[got] = int'(bus.m_re);
        yi[got] = int'(bus.m_im);
        yl[got] = bus.m_last;
        got++;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_ready=%b m_valid=%b m_last=%b busy=%b ovf=%b, want 1 0 0 0 0",
               bus.s_ready, bus.m_valid, bus.m_last, busy, ovf);
    end
    n_checks++;
    if (bus.m_re !== 16'sd0 || bus.m_im !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_data: m_re=%0d m_im=%0d, want 0 0", bus.m_re, bus.m_im);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b busy=%b, want 1 0", bus.s_ready, busy);
    end
  endtask

  task automatic test_impulse();
    bit to;
    int cyc, got;
    for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
    xr[0] = 1000;
    send_frame(0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL imp_send: timeout=1, want 0"); end
    n_checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_re !== 16'sd0) begin
      n_fail++;
      $display("FAIL imp_compute_flags: busy=%b s_ready=%b m_valid=%b m_re=%0d, want 1 0 0 0",
               busy, bus.s_ready, bus.m_valid, bus.m_re);
    end
    cyc = 0;
    while (!bus.m_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32) begin n_fail++; $display("FAIL imp_latency: got %0d cycles, want 32", cyc); end
    recv_frame(got);
    n_checks++;
    if (got != N) begin n_fail++; $display("FAIL imp_count: got %0d bins, want %0d", got, N); end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (yr[j] !== IMP || yi[j] !== 0 || yl[j] !== (j == N - 1)) begin
        n_fail++;
        $display("FAIL imp_bin%0d: re=%0d im=%0d last=%b, want %0d 0 %b", j, yr[j], yi[j], yl[j], IMP, j == N - 1);
      end
    end
  endtask

  task automatic test_dc();
    bit to;
    int got;
    for (int k = 0; k < N; k++) begin xr[k] = 1000; xi[k] = 0; end
    send_frame(0, to);
    recv_frame(got);
    n_checks++;
    if (to || got != N) begin n_fail++; $display("FAIL dc_transfer: timeout=%b bins=%0d, want 0 %0d", to, got, N); end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (yr[j] !== ((j == 0) ? DC0 : 0) || yi[j] !== 0) begin
        n_fail++;
        $display("FAIL dc_bin%0d: re=%0d im=%0d, want %0d 0", j, yr[j], yi[j], (j == 0) ? DC0 : 0);
      end
    end
    n_checks++;
    if (y_ovf !== 1'b0) begin n_fail++; $display("FAIL dc_ovf: ovf=%b, want 0", y_ovf); end
  endtask

  task automatic test_cosine();
    bit to;
    int got, er;
    for (int k = 0; k < N; k++) begin xr[k] = COS_TAB[k]; xi[k] = 0; end
    send_frame(1, to);
    recv_frame(got);
    n_checks++;
    if (to || got != N) begin n_fail++; $display("FAIL cos_transfer: timeout=%b bins=%0d, want 0 %0d", to, got, N); end
    for (int j = 0; j < N; j++) begin
      er = (j == 1 || j == N - 1) ? COS_PEAK : 0;
      n_checks++;
      if (iabs(yr[j] - er) > COS_TOL || iabs(yi[j]) > COS_TOL) begin
        n_fail++;
        $display("FAIL cos_bin%0d: re=%0d im=%0d, want %0d 0 within %0d", j, yr[j], yi[j], er, COS_TOL);
      end
    end
    n_checks++;
    if (y_ovf !== 1'b0) begin n_fail++; $display("FAIL cos_ovf: ovf=%b, want 0", y_ovf); end
  endtask

  task automatic test_overflow();
    bit to, t;
    int got;
    for (int k = 0; k < N; k++) begin xr[k] = 30000; xi[k] = 0; end
    send_frame(0, to);
    recv_frame(got);
    n_checks++;
    if (y_ovf !== OVF_EXP) begin n_fail++; $display("FAIL ovf_at_output: ovf=%b, want %b", y_ovf, OVF_EXP); end
    repeat (3) tick();
    n_checks++;
    if (ovf !== OVF_EXP || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b s_ready=%b, want %b 1", ovf, bus.s_ready, OVF_EXP);
    end
    send_sample(1000, 0, t);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b, want 0", ovf); end
    for (int k = 1; k < N; k++) send_sample(0, 0, t);
    recv_frame(got);
    n_checks++;
    if (got != N || yr[5] !== IMP) begin
      n_fail++;
      $display("FAIL ovf_next_frame: bins=%0d bin5=%0d, want %0d %0d", got, yr[5], N, IMP);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int got = 0, cyc = 0, held = 0, h_re = 0, h_im = 0;
    for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
    xr[0] = 1000;
    xr[8] = 1000;
    send_frame(0, to);
    bus.m_ready = 1'b1;
    while (got < N && cyc < 2000) begin
      if (bus.m_valid) begin
        if (got == 3 && held < 5) begin
          bus.m_ready = 1'b0;
          if (held == 0) begin
            h_re = int'(bus.m_re);
            h_im = int'(bus.m_im);
          end else begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || int'(bus.m_re) !== h_re || int'(bus.m_im) !== h_im || bus.m_last !== 1'b0) begin
              n_fail++;
              $display("FAIL bp_hold%0d: valid=%b re=%0d im=%0d last=%b, want 1 %0d %0d 0",
                       held, bus.m_valid, bus.m_re, bus.m_im, bus.m_last, h_re, h_im);
            end
          end
          held++;
        end else begin
          bus.m_ready = 1'b1;
          yr[got] = int'(bus.m_re);
          yi[got] = int'(bus.m_im);
          yl[got] = bus.m_last;
          got++;
        end
      end
      tick();
      cyc++;
    end
    bus.m_ready = 1'b1;
    n_checks++;
    if (to || got != N || held != 5) begin
      n_fail++;
      $display("FAIL bp_transfer: timeout=%b bins=%0d stalls=%0d, want 0 %0d 5", to, got, held, N);
    end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (yr[j] !== ((j % 2 == 0) ? PAIR : 0) || yi[j] !== 0 || yl[j] !== (j == N - 1)) begin
        n_fail++;
        $display("FAIL bp_bin%0d: re=%0d im=%0d last=%b, want %0d 0 %b",
                 j, yr[j], yi[j], yl[j], (j % 2 == 0) ? PAIR : 0, j == N - 1);
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    bit to;
    int got;
    for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
    xr[0] = 1000;
    for (int k = 1; k < N; k++) xr[k] = 777;
    send_frame(0, to);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: m_valid=%b busy=%b s_ready=%b, want 0 0 1", bus.m_valid, busy, bus.s_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int k = 1; k < N; k++) xr[k] = 0;
    send_frame(0, to);
    recv_frame(got);
    n_checks++;
    if (to || got != N) begin n_fail++; $display("FAIL rst_transfer: timeout=%b bins=%0d, want 0 %0d", to, got, N); end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (yr[j] !== IMP || yi[j] !== 0 || yl[j] !== (j == N - 1)) begin
        n_fail++;
        $display("FAIL rst_bin%0d: re=%0d im=%0d last=%b, want %0d 0 %b", j, yr[j], yi[j], yl[j], IMP, j == N - 1);
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_re    = '0;
    bus.s_im    = '0;
    bus.m_ready = 1'b1;
    test_reset();
    test_impulse();
    test_dc();
    test_cosine();
    test_overflow();
    test_back_to_back();
    test_reset_mid_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
